// File: rtl/trashbin_pkg.sv
// Shared phase encoding, trap causes and instruction width for the Trashbin core sequencer.
package trashbin_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    FETCH,
    FETCH_WAIT,
    EXECUTE,
    MEM_WAIT,
    WRITEBACK,
    HALT
  } phaseType;

  localparam logic [1:0] TRAP_NONE       = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL    = 2'd1;
  localparam logic [1:0] TRAP_MISALIGNED = 2'd2;
  localparam logic [1:0] TRAP_TIMEOUT    = 2'd3;

endpackage

// File: rtl/trashbin_pc_unit.sv
// Program counter register: loads RESET_PC on reset, then steps by 4 or takes a branch redirect.
module trashbin_pc_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CoreClock,
  input  logic              CoreResetN,
  input  logic              advance,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  output logic [ADDR_W-1:0] programCounter
);

  // The increment wraps modulo 2^ADDR_W with no overflow indication.
  always_ff @(posedge CoreClock or negedge CoreResetN) begin
    if (!CoreResetN) begin
      programCounter <= RESET_PC;
    end else if (advance) begin
      programCounter <= branchTaken ? branchTarget : programCounter + ADDR_W'(4);
    end
  end

endmodule

// File: rtl/trashbin_core_sequencer.sv
// Fetch/execute/memory/writeback phase sequencer for the Trashbin core.
// Define TRASHBIN_SEQ_TIMEOUT_EN to bound each bus wait to TIMEOUT_CYCLES cycles.
module trashbin_core_sequencer
  import trashbin_pkg::*;
#(
  parameter int                XLEN           = 32,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic               CoreClock,
  input  logic               CoreResetN,
  output logic [ADDR_W-1:0]  AddressBus,
  output logic               ReadAssert,
  output logic               WriteAssert,
  input  logic [XLEN-1:0]    DataReadBus,
  output logic [XLEN-1:0]    DataWriteBus,
  input  logic               ReadOK,
  input  logic               WriteOK,
  output logic [INSTR_W-1:0] CurrentInstruction,
  input  logic               InvalidInstruction,
  input  logic               WritesRegisterFile,
  input  logic               ReadsRam,
  input  logic               WritesRam,
  input  logic               BranchTaken,
  input  logic [XLEN-1:0]    ALU_Result,
  input  logic [ADDR_W-1:0]  BranchTarget,
  input  logic [XLEN-1:0]    StoreData,
  output logic               RegisterWriteEnable,
  output logic [XLEN-1:0]    RegisterWriteData,
  output logic [ADDR_W-1:0]  ProgramCounter,
  output logic               Halted,
  output logic [1:0]         TrapCause
);

  phaseType          phase;
  logic              isLoad;
  logic [ADDR_W-1:0] memAddress;
  logic [XLEN-1:0]   loadData;
  logic              memOp;
  logic              inWait;
  logic              waitAck;
  logic              timeoutHit;

  assign memOp   = ReadsRam | WritesRam;
  assign inWait  = (phase == FETCH_WAIT) || (phase == MEM_WAIT);
  assign waitAck = ((phase == FETCH_WAIT) && ReadOK) ||
                   ((phase == MEM_WAIT) && (isLoad ? ReadOK : WriteOK));

`ifdef TRASHBIN_SEQ_TIMEOUT_EN
  localparam int WaitW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WaitW-1:0] waitCount;

  // Held at zero outside the wait states, so every wait starts counting from zero.
  always_ff @(posedge CoreClock or negedge CoreResetN) begin
    if (!CoreResetN) begin
      waitCount <= '0;
    end else if (!inWait || waitAck) begin
      waitCount <= '0;
    end else begin
      waitCount <= waitCount + 1'b1;
    end
  end

  assign timeoutHit = inWait && !waitAck && (waitCount == WaitW'(TIMEOUT_CYCLES - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge CoreClock or negedge CoreResetN) begin
    if (!CoreResetN) begin
      phase              <= FETCH;
      CurrentInstruction <= '0;
      isLoad             <= 1'b0;
      memAddress         <= '0;
      DataWriteBus       <= '0;
      loadData           <= '0;
      Halted             <= 1'b0;
      TrapCause          <= TRAP_NONE;
    end else begin
      case (phase)
        FETCH: phase <= FETCH_WAIT;
        FETCH_WAIT: begin
          if (ReadOK) begin
            CurrentInstruction <= DataReadBus[INSTR_W-1:0];
            phase              <= EXECUTE;
          end else if (timeoutHit) begin
            phase     <= HALT;
            Halted    <= 1'b1;
            TrapCause <= TRAP_TIMEOUT;
          end
        end
        EXECUTE: begin
          if (InvalidInstruction || (ReadsRam && WritesRam)) begin
            phase     <= HALT;
            Halted    <= 1'b1;
            TrapCause <= TRAP_ILLEGAL;
          end else if ((memOp && (ALU_Result[1:0] != 2'b00)) ||
                       (BranchTaken && (BranchTarget[1:0] != 2'b00))) begin
            phase     <= HALT;
            Halted    <= 1'b1;
            TrapCause <= TRAP_MISALIGNED;
          end else if (memOp) begin
            memAddress   <= ALU_Result[ADDR_W-1:0];
            DataWriteBus <= StoreData;
            isLoad       <= ReadsRam;
            phase        <= MEM_WAIT;
          end else begin
            isLoad <= 1'b0;
            phase  <= WRITEBACK;
          end
        end
        MEM_WAIT: begin
          if (waitAck) begin
            if (isLoad) begin
              loadData <= DataReadBus;
            end
            phase <= WRITEBACK;
          end else if (timeoutHit) begin
            phase     <= HALT;
            Halted    <= 1'b1;
            TrapCause <= TRAP_TIMEOUT;
          end
        end
        WRITEBACK: phase <= FETCH;
        HALT:      phase <= HALT;
        default:   phase <= FETCH;
      endcase
    end
  end

  trashbin_pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) pcUnit (
    .CoreClock      (CoreClock),
    .CoreResetN     (CoreResetN),
    .advance        (phase == WRITEBACK),
    .branchTaken    (BranchTaken),
    .branchTarget   (BranchTarget),
    .programCounter (ProgramCounter)
  );

  // Strobes are gated by the reset pin so they drop the instant reset is asserted.
  assign ReadAssert  = CoreResetN &&
                       ((phase == FETCH) || (phase == FETCH_WAIT) || ((phase == MEM_WAIT) && isLoad));
  assign WriteAssert = CoreResetN && (phase == MEM_WAIT) && !isLoad;
  assign AddressBus  = (phase == MEM_WAIT) ? memAddress : ProgramCounter;

  assign RegisterWriteEnable = (phase == WRITEBACK) && WritesRegisterFile;
  assign RegisterWriteData   = isLoad ? loadData : ALU_Result;

endmodule

// File: tb/tb_trashbin_core_sequencer.sv
// Self-checking bench for trashbin_core_sequencer; register writes are checked against a scoreboard queue.
module tb_trashbin_core_sequencer;

  localparam int          XLEN   = 32;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] RST_PC = 32'h100;

  logic              CoreClock;
  logic              CoreResetN;
  logic [ADDR_W-1:0] AddressBus;
  logic              ReadAssert;
  logic              WriteAssert;
  logic [XLEN-1:0]   DataReadBus;
  logic [XLEN-1:0]   DataWriteBus;
  logic              ReadOK;
  logic              WriteOK;
  logic [31:0]       CurrentInstruction;
  logic              InvalidInstruction;
  logic              WritesRegisterFile;
  logic              ReadsRam;
  logic              WritesRam;
  logic              BranchTaken;
  logic [XLEN-1:0]   ALU_Result;
  logic [ADDR_W-1:0] BranchTarget;
  logic [XLEN-1:0]   StoreData;
  logic              RegisterWriteEnable;
  logic [XLEN-1:0]   RegisterWriteData;
  logic [ADDR_W-1:0] ProgramCounter;
  logic              Halted;
  logic [1:0]        TrapCause;

  int checkCount = 0;
  int passCount  = 0;
  logic [XLEN-1:0] expWrites[$];

  trashbin_core_sequencer #(
    .XLEN           (XLEN),
    .ADDR_W         (ADDR_W),
    .RESET_PC       (RST_PC),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .CoreClock           (CoreClock),
    .CoreResetN          (CoreResetN),
    .AddressBus          (AddressBus),
    .ReadAssert          (ReadAssert),
    .WriteAssert         (WriteAssert),
    .DataReadBus         (DataReadBus),
    .DataWriteBus        (DataWriteBus),
    .ReadOK              (ReadOK),
    .WriteOK             (WriteOK),
    .CurrentInstruction  (CurrentInstruction),
    .InvalidInstruction  (InvalidInstruction),
    .WritesRegisterFile  (WritesRegisterFile),
    .ReadsRam            (ReadsRam),
    .WritesRam           (WritesRam),
    .BranchTaken         (BranchTaken),
    .ALU_Result          (ALU_Result),
    .BranchTarget        (BranchTarget),
    .StoreData           (StoreData),
    .RegisterWriteEnable (RegisterWriteEnable),
    .RegisterWriteData   (RegisterWriteData),
    .ProgramCounter      (ProgramCounter),
    .Halted              (Halted),
    .TrapCause           (TrapCause)
  );

  initial CoreClock = 1'b0;
  always #5 CoreClock = ~CoreClock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, want completion before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard: every register-file write must match the oldest expected value.
  always @(negedge CoreClock) begin
    logic [XLEN-1:0] expData;
    if (CoreResetN === 1'b1 && RegisterWriteEnable === 1'b1) begin
      checkCount++;
      if (expWrites.size() == 0) begin
        $display("[TB] FAIL unexpected_write: got data %h, want no write", RegisterWriteData);
      end else begin
        expData = expWrites.pop_front();
        if (RegisterWriteData !== expData)
          $display("[TB] FAIL writeback_data: got %h want %h", RegisterWriteData, expData);
        else
          passCount++;
      end
    end
  end

  task automatic nextCycle();
    @(posedge CoreClock);
    #1;
  endtask

  task automatic clearControls();
    DataReadBus        = '0;
    ReadOK             = 1'b1;
    WriteOK            = 1'b0;
    InvalidInstruction = 1'b0;
    WritesRegisterFile = 1'b0;
    ReadsRam           = 1'b0;
    WritesRam          = 1'b0;
    BranchTaken        = 1'b0;
    ALU_Result         = '0;
    BranchTarget       = '0;
    StoreData          = '0;
  endtask

  // Returns one time unit after release, in cycle 1 (FETCH) of the first instruction.
  task automatic applyReset();
    CoreResetN = 1'b0;
    clearControls();
    repeat (2) @(posedge CoreClock);
    @(negedge CoreClock);
    CoreResetN = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    CoreResetN = 1'b0;
    clearControls();
    repeat (2) @(posedge CoreClock);
    #1;
    checkCount++; if (ReadAssert !== 1'b0) $display("[TB] FAIL reset_read_strobe: got %b want 0", ReadAssert); else passCount++;
    checkCount++; if (WriteAssert !== 1'b0) $display("[TB] FAIL reset_write_strobe: got %b want 0", WriteAssert); else passCount++;
    checkCount++; if (RegisterWriteEnable !== 1'b0) $display("[TB] FAIL reset_rf_we: got %b want 0", RegisterWriteEnable); else passCount++;
    checkCount++; if (Halted !== 1'b0) $display("[TB] FAIL reset_halted: got %b want 0", Halted); else passCount++;
    checkCount++; if (TrapCause !== 2'd0) $display("[TB] FAIL reset_cause: got %0d want 0", TrapCause); else passCount++;
    checkCount++; if (ProgramCounter !== RST_PC) $display("[TB] FAIL reset_pc: got %h want %h", ProgramCounter, RST_PC); else passCount++;
    checkCount++; if (AddressBus !== RST_PC) $display("[TB] FAIL reset_addr: got %h want %h", AddressBus, RST_PC); else passCount++;
    checkCount++; if (CurrentInstruction !== 32'h0) $display("[TB] FAIL reset_instr: got %h want 0", CurrentInstruction); else passCount++;
    checkCount++; if (DataWriteBus !== 32'h0) $display("[TB] FAIL reset_wdata: got %h want 0", DataWriteBus); else passCount++;
  endtask

  task automatic test_alu_op();
    int wbCycle = 0;
    DataReadBus        = 32'h00A00093;
    ALU_Result         = 32'h55;
    WritesRegisterFile = 1'b1;
    expWrites.push_back(32'h55);
    @(negedge CoreClock);
    CoreResetN = 1'b1;
    #1;
    checkCount++; if (AddressBus !== RST_PC) $display("[TB] FAIL alu_fetch_addr: got %h want %h", AddressBus, RST_PC); else passCount++;
    checkCount++; if (ReadAssert !== 1'b1) $display("[TB] FAIL alu_fetch_strobe: got %b want 1", ReadAssert); else passCount++;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) nextCycle();
      if (RegisterWriteEnable === 1'b1) wbCycle = c;
    end
    checkCount++; if (wbCycle !== 4) $display("[TB] FAIL alu_wb_cycle: got %0d want 4", wbCycle); else passCount++;
    checkCount++; if (CurrentInstruction !== 32'h00A00093) $display("[TB] FAIL alu_instr: got %h want 00a00093", CurrentInstruction); else passCount++;
    nextCycle();
    checkCount++; if (ProgramCounter !== 32'h104) $display("[TB] FAIL alu_pc: got %h want 104", ProgramCounter); else passCount++;
  endtask

  task automatic test_fetch_wait();
    int readCycles = 0;
    int wbCycle = 0;
    DataReadBus = 32'h12345678;
    ALU_Result  = 32'h77;
    expWrites.push_back(32'h77);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) nextCycle();
      ReadOK = (c == 5);
      if (ReadAssert === 1'b1) readCycles++;
      if (RegisterWriteEnable === 1'b1) wbCycle = c;
      if (c == 5) begin
        checkCount++; if (CurrentInstruction !== 32'h00A00093) $display("[TB] FAIL fw_instr_early: got %h want 00a00093", CurrentInstruction); else passCount++;
      end
      if (c == 6) begin
        checkCount++; if (CurrentInstruction !== 32'h12345678) $display("[TB] FAIL fw_instr_latched: got %h want 12345678", CurrentInstruction); else passCount++;
      end
    end
    // FETCH cycle plus four FETCH_WAIT cycles (three waits, then the acknowledge).
    checkCount++; if (readCycles !== 5) $display("[TB] FAIL fw_read_cycles: got %0d want 5", readCycles); else passCount++;
    checkCount++; if (wbCycle !== 7) $display("[TB] FAIL fw_wb_cycle: got %0d want 7", wbCycle); else passCount++;
    nextCycle();
    ReadOK = 1'b1;
    checkCount++; if (ProgramCounter !== 32'h108) $display("[TB] FAIL fw_pc: got %h want 108", ProgramCounter); else passCount++;
  endtask

  task automatic test_load();
    int wbCycle = 0;
    DataReadBus        = 32'h0000A083;
    ReadsRam           = 1'b1;
    WritesRegisterFile = 1'b1;
    ALU_Result         = 32'h20;
    expWrites.push_back(32'hDEADBEEF);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) nextCycle();
      if (c == 3) DataReadBus = 32'hDEADBEEF;
      if (RegisterWriteEnable === 1'b1) wbCycle = c;
      if (c == 4) begin
        checkCount++; if (AddressBus !== 32'h20) $display("[TB] FAIL load_addr: got %h want 20", AddressBus); else passCount++;
        checkCount++; if (ReadAssert !== 1'b1) $display("[TB] FAIL load_read_strobe: got %b want 1", ReadAssert); else passCount++;
        checkCount++; if (WriteAssert !== 1'b0) $display("[TB] FAIL load_write_strobe: got %b want 0", WriteAssert); else passCount++;
      end
    end
    checkCount++; if (wbCycle !== 5) $display("[TB] FAIL load_wb_cycle: got %0d want 5", wbCycle); else passCount++;
    nextCycle();
    ReadsRam = 1'b0;
    checkCount++; if (ProgramCounter !== 32'h10C) $display("[TB] FAIL load_pc: got %h want 10c", ProgramCounter); else passCount++;
  endtask

  task automatic test_store();
    int writeCycles = 0;
    DataReadBus        = 32'h0020A223;
    WritesRam          = 1'b1;
    WritesRegisterFile = 1'b0;
    ALU_Result         = 32'h24;
    StoreData          = 32'hCAFEF00D;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) nextCycle();
      WriteOK = (c == 5);
      if (WriteAssert === 1'b1) writeCycles++;
      if (c == 4) begin
        checkCount++; if (AddressBus !== 32'h24) $display("[TB] FAIL store_addr: got %h want 24", AddressBus); else passCount++;
        checkCount++; if (DataWriteBus !== 32'hCAFEF00D) $display("[TB] FAIL store_data: got %h want cafef00d", DataWriteBus); else passCount++;
        checkCount++; if (ReadAssert !== 1'b0) $display("[TB] FAIL store_read_strobe: got %b want 0", ReadAssert); else passCount++;
      end
    end
    checkCount++; if (writeCycles !== 2) $display("[TB] FAIL store_write_cycles: got %0d want 2", writeCycles); else passCount++;
    nextCycle();
    WritesRam = 1'b0;
    WriteOK   = 1'b0;
    checkCount++; if (ProgramCounter !== 32'h110) $display("[TB] FAIL store_pc: got %h want 110", ProgramCounter); else passCount++;
  endtask

  task automatic test_branch_wrap();
    DataReadBus        = 32'h0000006F;
    BranchTaken        = 1'b1;
    BranchTarget       = 32'hFFFFFFFC;
    WritesRegisterFile = 1'b1;
    ALU_Result         = 32'h114;
    expWrites.push_back(32'h114);
    repeat (4) nextCycle();
    BranchTaken = 1'b0;
    checkCount++; if (ProgramCounter !== 32'hFFFFFFFC) $display("[TB] FAIL branch_pc: got %h want fffffffc", ProgramCounter); else passCount++;
    checkCount++; if (AddressBus !== 32'hFFFFFFFC) $display("[TB] FAIL branch_fetch_addr: got %h want fffffffc", AddressBus); else passCount++;
    ALU_Result = 32'h99;
    expWrites.push_back(32'h99);
    repeat (4) nextCycle();
    checkCount++; if (ProgramCounter !== 32'h0) $display("[TB] FAIL wrap_pc: got %h want 0", ProgramCounter); else passCount++;
  endtask

  task automatic test_misaligned_store();
    logic writeSeen = 1'b0;
    WritesRam          = 1'b1;
    WritesRegisterFile = 1'b0;
    ALU_Result         = 32'h22;
    StoreData          = 32'h11111111;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) nextCycle();
      if (WriteAssert === 1'b1) writeSeen = 1'b1;
    end
    WritesRam = 1'b0;
    checkCount++; if (writeSeen !== 1'b0) $display("[TB] FAIL mis_write_strobe: got %b want 0", writeSeen); else passCount++;
    checkCount++; if (Halted !== 1'b1) $display("[TB] FAIL mis_halted: got %b want 1", Halted); else passCount++;
    checkCount++; if (TrapCause !== 2'd2) $display("[TB] FAIL mis_cause: got %0d want 2", TrapCause); else passCount++;
    checkCount++; if (ProgramCounter !== 32'h0) $display("[TB] FAIL mis_pc: got %h want 0", ProgramCounter); else passCount++;
    checkCount++; if (ReadAssert !== 1'b0) $display("[TB] FAIL mis_read_strobe: got %b want 0", ReadAssert); else passCount++;
  endtask

  task automatic test_misaligned_branch();
    applyReset();
    BranchTaken        = 1'b1;
    BranchTarget       = 32'h202;
    WritesRegisterFile = 1'b1;
    repeat (5) nextCycle();
    checkCount++; if (TrapCause !== 2'd2) $display("[TB] FAIL mbr_cause: got %0d want 2", TrapCause); else passCount++;
    checkCount++; if (ProgramCounter !== RST_PC) $display("[TB] FAIL mbr_pc: got %h want %h", ProgramCounter, RST_PC); else passCount++;
  endtask

  task automatic test_illegal_reset();
    applyReset();
    DataReadBus        = 32'hFFFFFFFF;
    InvalidInstruction = 1'b1;
    WritesRegisterFile = 1'b1;
    repeat (5) nextCycle();
    checkCount++; if (Halted !== 1'b1) $display("[TB] FAIL ill_halted: got %b want 1", Halted); else passCount++;
    checkCount++; if (TrapCause !== 2'd1) $display("[TB] FAIL ill_cause: got %0d want 1", TrapCause); else passCount++;
    #2;
    CoreResetN = 1'b0;
    #1;
    checkCount++; if (TrapCause !== 2'd0) $display("[TB] FAIL rst_cause: got %0d want 0", TrapCause); else passCount++;
    checkCount++; if (Halted !== 1'b0) $display("[TB] FAIL rst_halted: got %b want 0", Halted); else passCount++;
    checkCount++; if (ReadAssert !== 1'b0) $display("[TB] FAIL rst_read_strobe: got %b want 0", ReadAssert); else passCount++;
    clearControls();
    @(negedge CoreClock);
    CoreResetN = 1'b1;
    #1;
    checkCount++; if (ReadAssert !== 1'b1) $display("[TB] FAIL rst_fetch_strobe: got %b want 1", ReadAssert); else passCount++;
    checkCount++; if (AddressBus !== RST_PC) $display("[TB] FAIL rst_fetch_addr: got %h want %h", AddressBus, RST_PC); else passCount++;
  endtask

  task automatic test_timeout();
    applyReset();
    ReadOK = 1'b0;
`ifdef TRASHBIN_SEQ_TIMEOUT_EN
    begin
      int readCycles = 0;
      for (int c = 1; c <= 40; c++) begin
        if (c > 1) nextCycle();
        if (Halted === 1'b1) break;
        if (ReadAssert === 1'b1) readCycles++;
      end
      checkCount++; if (Halted !== 1'b1) $display("[TB] FAIL to_halted: got %b want 1", Halted); else passCount++;
      checkCount++; if (readCycles !== 9) $display("[TB] FAIL to_read_cycles: got %0d want 9", readCycles); else passCount++;
      checkCount++; if (TrapCause !== 2'd3) $display("[TB] FAIL to_cause: got %0d want 3", TrapCause); else passCount++;
      checkCount++; if (ReadAssert !== 1'b0) $display("[TB] FAIL to_read_strobe: got %b want 0", ReadAssert); else passCount++;
    end
`else
    repeat (1000) nextCycle();
    checkCount++; if (ReadAssert !== 1'b1) $display("[TB] FAIL wait_read_strobe: got %b want 1", ReadAssert); else passCount++;
    checkCount++; if (Halted !== 1'b0) $display("[TB] FAIL wait_halted: got %b want 0", Halted); else passCount++;
    checkCount++; if (TrapCause !== 2'd0) $display("[TB] FAIL wait_cause: got %0d want 0", TrapCause); else passCount++;
`endif
  endtask

  initial begin
    $display("[TB] starting trashbin_core_sequencer bench");
    test_reset();
    test_alu_op();
    test_fetch_wait();
    test_load();
    test_store();
    test_branch_wrap();
    test_misaligned_store();
    test_misaligned_branch();
    test_illegal_reset();
    test_timeout();
    checkCount++;
    if (expWrites.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d pending writes want 0", expWrites.size());
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
